// File: rtl/brisc_pkg.sv
// Shared constants and types for the memory-side controller.
package brisc_pkg;

    localparam int ADDRESS_WIDTH    = 32;
    localparam int CACHE_LINE_WIDTH = 128;
    localparam int MEM_LATENCY      = 5;

    // Bit positions of the one-hot arbiter select.
    localparam int SEL_I = 0;
    localparam int SEL_D = 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } mem_state_e;

    // Byte-offset bits inside one line.
    function automatic int offset_width(input int line_width);
        return $clog2(line_width / 8);
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Cache-to-memory bus: miss requests and dirty writebacks in, grants and fills out.
interface mem_ctrl_if
    import brisc_pkg::*;
#(
    parameter int LINE_WIDTH = CACHE_LINE_WIDTH
);
    logic                     i_req;
    logic [ADDRESS_WIDTH-1:0] i_addr;
    logic                     d_req;
    logic [ADDRESS_WIDTH-1:0] d_addr;
    logic                     d_evict;
    logic [LINE_WIDTH-1:0]    d_evict_data;
    logic [ADDRESS_WIDTH-1:0] d_evict_addr;
    logic                     i_grant;
    logic                     d_grant;
    logic                     i_fill;
    logic                     d_fill;
    logic [LINE_WIDTH-1:0]    fill_data;
    logic [ADDRESS_WIDTH-1:0] fill_addr;

    modport master (
        output i_req, i_addr, d_req, d_addr, d_evict, d_evict_data, d_evict_addr,
        input  i_grant, d_grant, i_fill, d_fill, fill_data, fill_addr
    );

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_evict, d_evict_data, d_evict_addr,
        output i_grant, d_grant, i_fill, d_fill, fill_data, fill_addr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter; last_d=1 means dcache won last, so icache wins a tie.
module mem_arbiter
    import brisc_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last_d,
    output logic [1:0] sel
);

    // One-hot pick, alternating on simultaneous requests.
    always_comb begin
        sel = 2'b00;
        if (i_req && d_req) begin
            sel[SEL_I] = last_d;
            sel[SEL_D] = !last_d;
        end else if (i_req) begin
            sel[SEL_I] = 1'b1;
        end else if (d_req) begin
            sel[SEL_D] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Backing-store controller shared by icache and dcache: one transaction at a time,
// dirty writebacks ahead of reads, fixed access latency.
//
// state | meaning
// IDLE  | accepting evict or read request
// WRITE | latency countdown, line written when counter hits 0
// READ  | latency countdown for a fill
// RESP  | one-cycle fill strobe to the owning cache
module mem_ctrl
    import brisc_pkg::*;
#(
    parameter int NUM_LINES  = 256,
    parameter int LINE_WIDTH = CACHE_LINE_WIDTH,
    parameter int LATENCY    = MEM_LATENCY
) (
    input logic       clk,
    input logic       reset,
    mem_ctrl_if.slave bus
);

    localparam int OFF_W = offset_width(LINE_WIDTH);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'((1 << OFF_W) - 1);

    mem_state_e               state, state_nxt;
    logic [3:0]               cnt, cnt_nxt;
    logic                     last_d;
    logic                     owner_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0]    data_q;
    logic [1:0]               sel;
    logic [IDX_W-1:0]         idx;
    logic                     mem_we;
    logic [LINE_WIDTH-1:0]    mem [NUM_LINES];

    mem_arbiter u_arb (
        .i_req  (bus.i_req),
        .d_req  (bus.d_req),
        .last_d (last_d),
        .sel    (sel)
    );

    // Latched address has the offset already cleared, so it doubles as fill_addr.
    assign idx    = addr_q[OFF_W +: IDX_W];
    assign mem_we = (state == WRITE) && (cnt == 4'd0);

    // State register and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter and bus outputs.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus.i_grant   = 1'b0;
        bus.d_grant   = 1'b0;
        bus.i_fill    = 1'b0;
        bus.d_fill    = 1'b0;
        bus.fill_data = '0;
        bus.fill_addr = '0;
        case (state)
            IDLE: begin
                if (bus.d_evict) begin
                    state_nxt = WRITE;
                    cnt_nxt   = CNT_LOAD;
                end else if (sel != 2'b00) begin
                    state_nxt = READ;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WRITE: begin
                bus.d_grant = 1'b1;
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            READ: begin
                bus.i_grant = !owner_d;
                bus.d_grant = owner_d;
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                bus.i_grant   = !owner_d;
                bus.d_grant   = owner_d;
                bus.i_fill    = !owner_d;
                bus.d_fill    = owner_d;
                bus.fill_data = mem[idx];
                bus.fill_addr = addr_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the accepted transaction; inputs are ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            owner_d <= 1'b0;
            last_d  <= 1'b1;
        end else if (state == IDLE) begin
            if (bus.d_evict) begin
                addr_q  <= bus.d_evict_addr & ~OFF_MASK;
                data_q  <= bus.d_evict_data;
                owner_d <= 1'b1;
            end else if (sel != 2'b00) begin
                addr_q  <= (sel[SEL_D] ? bus.d_addr : bus.i_addr) & ~OFF_MASK;
                owner_d <= sel[SEL_D];
                last_d  <= sel[SEL_D];
            end
        end
    end

    // Backing store has no reset; a write cut short by reset never reaches here.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= data_q;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 256, number of memory lines in the backing store.
REQ-002 SHALL have parameter LINE_WIDTH, default CACHE_LINE_WIDTH (128), bits per line.
REQ-003 SHALL have parameter LATENCY, default MEM_LATENCY (5), access cycles, legal range 1..15.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: ports clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous active-low reset).
REQ-005 SHALL have i_req, input, 1, icache miss request.
REQ-006 SHALL have i_addr, input, ADDRESS_WIDTH, icache miss address.
REQ-007 SHALL have d_req, input, 1, dcache miss request.
REQ-008 SHALL have d_addr, input, ADDRESS_WIDTH, dcache miss address.
REQ-009 SHALL have d_evict, d_evict_data, d_evict_addr: inputs, 1/LINE_WIDTH/ADDRESS_WIDTH, dcache dirty-line writeback.
REQ-010 SHALL have i_grant and d_grant, outputs, 1 each, port owns the memory.
REQ-011 SHALL have i_fill and d_fill, outputs, 1 each, one-cycle fill strobe to the matching cache.
REQ-012 SHALL have fill_data (LINE_WIDTH) and fill_addr (ADDRESS_WIDTH) outputs, shared by both caches.

Function
REQ-013 SHALL implement FSM IDLE, WRITE, READ, RESP plus a latency counter and a round-robin bit last_d.
REQ-014 In IDLE, d_evict SHALL take priority: go to WRITE, latch evict data/address, assert d_grant.
REQ-015 Otherwise in IDLE, one request SHALL go to READ with latched address and owner; on i_req and d_req together, grant the port not granted last (last_d=1 selects icache); last_d updates on every read grant.
REQ-016 On entry to WRITE/READ the counter SHALL load LATENCY-1 and decrement each cycle; at 0 WRITE writes the line and returns to IDLE, READ moves to RESP.
REQ-017 Timing: request seen in IDLE at cycle 0 -> grant high cycles 1..LATENCY+1, fill strobe in cycle LATENCY+1, IDLE in cycle LATENCY+2; eviction -> grant cycles 1..LATENCY, memory updated at end of cycle LATENCY.
REQ-018 Line index SHALL be addr[OFFSET_WIDTH +: log2(NUM_LINES)]; higher bits ignored (wrap modulo NUM_LINES); offset bits ignored.
REQ-019 In RESP, fill_data SHALL be the stored line and fill_addr the latched address with offset bits zeroed; only the owner's fill strobe rises.
REQ-020 fill_data/fill_addr SHALL be 0 outside RESP.
REQ-021 Inputs SHALL be ignored outside IDLE; a request dropped mid-READ still completes (strobe issued, cache ignores it).
REQ-022 Eviction followed by a read of the same line SHALL return the newly written data (write completes before read starts).
REQ-023 Grants SHALL be one-hot or zero at all times.

Reset
REQ-024 reset low SHALL asynchronously force IDLE, counter 0, last_d 1, all grants/fills/fill_data/fill_addr 0.
REQ-025 Reset mid-WRITE SHALL drop the write (memory unchanged); reset mid-READ drops the fill.
REQ-026 The memory array SHALL not be reset; simulation initial content is all zero.

Structure
REQ-027 MEM_LATENCY and the FSM state enum mem_state_e SHALL live in brisc_pkg alongside ADDRESS_WIDTH and CACHE_LINE_WIDTH.
REQ-028 The round-robin selection SHALL be a sub-module mem_arbiter (2-requester arbiter, inputs i_req/d_req/last_d, output one-hot select).

Verification
REQ-029 Single read: d_req, d_addr=0x40 at cycle 0, LATENCY=5 -> d_grant cycles 1..6, d_fill only in cycle 6, fill_addr=0x40, fill_data=0.
REQ-030 Writeback then read: d_evict, addr=0x1234_5670, data=0xDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0; then d_req addr 0x1234_5678 -> fill_data equals written line, fill_addr=0x1234_5670.
REQ-031 Contention: i_req and d_req held from cycle 0 after reset -> icache served first (i_fill cycle 6), dcache next (d_fill cycle 13), grants never overlap.
REQ-032 Evict priority: d_evict, d_req, i_req together -> WRITE first (d_grant cycles 1..5), then read grant per round-robin.
REQ-033 Reset mid-READ: reset low in cycle 3 -> all outputs 0 immediately, no fill strobe, IDLE after release.
REQ-034 Wrap: write line at addr 0x0000_0010, read addr 0x0000_1010 (NUM_LINES=256, 16-byte lines) -> same data returned.
